hdmi_cfg_sequencer: RTL and testbench
=====================================

# hdmi_cfg_sequencer

AXI4-Lite master that configures the `hdmi_wrap` register bank after reset or on demand. It writes `NUM_REGS` 32-bit words to consecutive word addresses from `BASE_ADDR`, reads every register back, and compares each readback against the value written. It then reports done or error. It sits between the PS/system control logic and the `hdmi_wrap` S00_AXI slave port and replaces software bring-up of the HDMI block.

## Interface
- `C_M_AXI_ADDR_WIDTH`, default 32: AXI address width.
- `C_M_AXI_DATA_WIDTH`, default 32: AXI data width; only 32 is supported.
- `NUM_REGS`, default 4: number of registers programmed, 1..16.
- `BASE_ADDR`, default 32'h0: address of register 0; register i is at `BASE_ADDR + 4*i`.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles spent waiting on any single AXI channel.
- `ACLK` in 1: single clock; all logic is rising-edge.
- `ARESETN` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle pulse that begins a sequence.
- `cfg_data` in 32*NUM_REGS: register values; word i is `[32*i+31:32*i]`; sampled on the accepted `start`.
- `busy` out 1: sequence in progress.
- `done` out 1: sticky; sequence completed with no error.
- `error` out 1: sticky; sequence aborted.
- `err_code` out 2: 01 = non-OKAY BRESP/RRESP, 10 = readback mismatch, 11 = timeout, 00 = none.
- `err_index` out 4: register index at which the error occurred.
- `M_AXI_AWADDR`/`AWPROT`(3)/`AWVALID` out, `M_AXI_AWREADY` in: write address channel.
- `M_AXI_WDATA`(32)/`WSTRB`(4)/`WVALID` out, `M_AXI_WREADY` in: write data channel.
- `M_AXI_BRESP`(2)/`BVALID` in, `M_AXI_BREADY` out: write response channel.
- `M_AXI_ARADDR`/`ARPROT`(3)/`ARVALID` out, `M_AXI_ARREADY` in: read address channel.
- `M_AXI_RDATA`(32)/`RRESP`(2)/`RVALID` in, `M_AXI_RREADY` out: read data channel.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE, ERR.
- IDLE: on `start`, latch `cfg_data` into the shadow array, set idx=0, clear `done`/`error`/`err_code`/`err_index`, go to WR_REQ.
- WR_REQ: drive `AWVALID` and `WVALID` together. `AWADDR` = BASE_ADDR+4*idx, `WDATA` = shadow[idx], `WSTRB` = 4'hF, `AWPROT`/`ARPROT` = 3'b000.
  - Each VALID drops independently on its own handshake (VALID&READY).
  - When both handshakes are complete, go to WR_RESP.
- WR_RESP: `BREADY` = 1. On BVALID:
  - BRESP != OKAY → ERR with code 01.
  - Otherwise idx++; if idx == NUM_REGS, set idx=0 and go to RD_REQ; else go to WR_REQ.
- RD_REQ: drive `ARVALID` with `ARADDR` = BASE_ADDR+4*idx; on handshake go to RD_DATA.
- RD_DATA: `RREADY` = 1. On RVALID:
  - RRESP != OKAY → code 01.
  - Else RDATA != shadow[idx] → code 10.
  - Else idx++; if idx == NUM_REGS go to DONE, else go to RD_REQ.
- Timeout: a per-state counter clears on every state entry. If it reaches TIMEOUT_CYCLES without the awaited handshake → ERR with code 11. All VALIDs drop on that transition. This is deliberate protocol abandonment; recovery requires reset of the slave.
- DONE/ERR: `done` or `error` is set and held. `start` re-runs the sequence from IDLE semantics and clears the flags.
- `start` while busy is ignored.
- Addresses are computed modulo 2^C_M_AXI_ADDR_WIDTH.

## Timing
- Reset: every VALID/READY output 0, `busy`/`done`/`error` = 0, `err_code`/`err_index` = 0, state IDLE. Reset is asynchronous, so a mid-transaction reset drops VALIDs immediately.
- Write issue timing: `busy` and `AWVALID`/`WVALID` rise on the clock edge after `start` is sampled.
- Write throughput: with AWREADY=WREADY=1 and BVALID one cycle after the handshake, one write takes 2 cycles. The next write's VALIDs assert in the cycle following BVALID&BREADY.
- Read throughput: with ARREADY=1 and RVALID the next cycle, one read takes 2 cycles.
- Best-case total: 4*NUM_REGS cycles from the `start` sample to `done`.
- `done`/`error` rise in the cycle after the final R/B handshake. `busy` falls in the same cycle.
- `BREADY` and `RREADY` are held high only in their wait states and are never asserted early.
- Outputs are registered; there is no combinational path from any READY input to any VALID output.

## Test plan
- Normal sequence: reset 200 ns, `start` with cfg = 1,2,3,4 against an AXI-Lite register slave.
  - Required: writes to 0x0, 0x4, 0x8, 0xC, then reads of the same addresses return 1..4.
  - Required: `done`=1, `error`=0, done 16 cycles after `start`.
- Channel skew: AWREADY delayed 3 cycles, WREADY immediate.
  - Required: WVALID drops after 1 cycle, AWVALID is held 4 cycles, exactly one B is accepted per register, sequence completes.
- Write error: slave returns SLVERR on the write to 0x8.
  - Required: `error`=1, `err_code`=01, `err_index`=2, no AR is ever issued.
- Readback mismatch: slave returns 0xDEAD for the read of 0x4.
  - Required: `err_code`=10, `err_index`=1, reads of 0x8/0xC are not issued.
- Timeout: ARREADY held 0 with TIMEOUT_CYCLES=16.
  - Required: ERR exactly 16 cycles after RD_REQ entry, `err_code`=11, ARVALID=0 afterwards.
- Reset and restart: ARESETN pulsed low during the second write.
  - Required: all VALIDs go to 0 asynchronously, `busy`=0.
  - Required: a new `start` after release redoes the full sequence and sets `done`.
  - Required: a `start` pulsed while busy has no effect.

Source files
------------

// File: rtl/hdmi_cfg_sequencer.sv
// AXI4-Lite master that writes NUM_REGS configuration words into the hdmi_wrap
// register bank, reads each one back, and reports done or a coded error.
module hdmi_cfg_sequencer #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter int                            TIMEOUT_CYCLES     = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic [32*NUM_REGS-1:0]          cfg_data,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [1:0]                      err_code,
  output logic [3:0]                      err_index,
  output logic [2:0]                      dbg_state,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic          aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, ar_valid_q, ar_valid_d;
  logic          b_ready_q, b_ready_d, r_ready_q, r_ready_d;
  logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]    code_q, code_d;
  logic [3:0]    eidx_q, eidx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit, load, last_idx;
  logic [31:0]   shadow_q [16];
  logic [31:0]   cfg_word [16];

  for (genvar g = 0; g < 16; g++) begin : g_cfg
    if (g < NUM_REGS) begin : g_used
      assign cfg_word[g] = cfg_data[32*g +: 32];
    end else begin : g_unused
      assign cfg_word[g] = '0;
    end
  end

  assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign last_idx = (idx_q == 4'(NUM_REGS - 1));

  // Handshake rule: a transfer happens on a rising ACLK edge where VALID and
  // READY are both high; a VALID, once raised, stays up until that edge.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    b_ready_d  = b_ready_q;
    r_ready_d  = r_ready_q;
    done_d     = done_q;
    error_d    = error_q;
    code_d     = code_q;
    eidx_d     = eidx_q;
    load       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          load       = 1'b1;
          idx_d      = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          code_d     = 2'b00;
          eidx_d     = '0;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        aw_valid_d = aw_valid_q & ~M_AXI_AWREADY;
        w_valid_d  = w_valid_q & ~M_AXI_WREADY;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          state_d   = S_WR_RESP;
        end else if (tmo_hit) begin
          aw_valid_d = 1'b0;
          w_valid_d  = 1'b0;
          error_d    = 1'b1;
          code_d     = 2'b11;
          eidx_d     = idx_q;
          state_d    = S_ERR;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          b_ready_d = 1'b0;
          if (M_AXI_BRESP != 2'b00) begin
            error_d = 1'b1;
            code_d  = 2'b01;
            eidx_d  = idx_q;
            state_d = S_ERR;
          end else if (last_idx) begin
            idx_d      = '0;
            ar_valid_d = 1'b1;
            state_d    = S_RD_REQ;
          end else begin
            idx_d      = idx_q + 4'd1;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = S_WR_REQ;
          end
        end else if (tmo_hit) begin
          b_ready_d = 1'b0;
          error_d   = 1'b1;
          code_d    = 2'b11;
          eidx_d    = idx_q;
          state_d   = S_ERR;
        end
      end
      S_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = S_RD_DATA;
        end else if (tmo_hit) begin
          ar_valid_d = 1'b0;
          error_d    = 1'b1;
          code_d     = 2'b11;
          eidx_d     = idx_q;
          state_d    = S_ERR;
        end
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          r_ready_d = 1'b0;
          if (M_AXI_RRESP != 2'b00) begin
            error_d = 1'b1;
            code_d  = 2'b01;
            eidx_d  = idx_q;
            state_d = S_ERR;
          end else if (M_AXI_RDATA != shadow_q[idx_q]) begin
            error_d = 1'b1;
            code_d  = 2'b10;
            eidx_d  = idx_q;
            state_d = S_ERR;
          end else if (last_idx) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d      = idx_q + 4'd1;
            ar_valid_d = 1'b1;
            state_d    = S_RD_REQ;
          end
        end else if (tmo_hit) begin
          r_ready_d = 1'b0;
          error_d   = 1'b1;
          code_d    = 2'b11;
          eidx_d    = idx_q;
          state_d   = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WR_REQ) || (state_d == S_WR_RESP) ||
             (state_d == S_RD_REQ) || (state_d == S_RD_DATA);
    // The wait counter restarts on every state entry so each channel gets its own budget.
    tmo_d  = (state_d != state_q || !busy_q) ? '0 : tmo_q + TW'(1);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= 2'b00;
      eidx_q     <= '0;
      tmo_q      <= '0;
      for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      code_q     <= code_d;
      eidx_q     <= eidx_d;
      tmo_q      <= tmo_d;
      if (load) begin
        for (int i = 0; i < 16; i++) shadow_q[i] <= cfg_word[i];
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = code_q;
  assign err_index     = eidx_q;
  assign dbg_state     = state_q;
  assign M_AXI_AWADDR  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
  assign M_AXI_ARADDR  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = aw_valid_q;
  assign M_AXI_WVALID  = w_valid_q;
  assign M_AXI_WDATA   = shadow_q[idx_q];
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_BREADY  = b_ready_q;
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_RREADY  = r_ready_q;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Bench for hdmi_cfg_sequencer: reactive AXI-Lite register slave, expected-value
// queues popped by a monitor on every handshake, directed scenarios.
module tb_hdmi_cfg_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_RD_REQ = 3'd3, ST_ERR = 3'd6;

  logic         ACLK, ARESETN, start;
  logic [127:0] cfg_data;
  logic         busy, done, error;
  logic [1:0]   err_code;
  logic [3:0]   err_index;
  logic [2:0]   dbg_state;
  logic [31:0]  M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
  logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]   M_AXI_WSTRB;
  logic         M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]   M_AXI_BRESP, M_AXI_RRESP;
  logic         M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic         M_AXI_RVALID, M_AXI_RREADY;

  hdmi_cfg_sequencer #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .NUM_REGS(4),
    .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .err_index(err_index), .dbg_state(dbg_state),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // Clock / reset
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  // Scoreboard queues
  logic [31:0] exp_aw_q[$], exp_w_q[$], exp_ar_q[$], exp_r_q[$];
  logic [7:0]  exp_end_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    fails++;
    $display("FAIL %s: got %0h expected no transfer", name, act);
  endtask

  // Slave model
  int          aw_delay = 0, aw_cnt = 0;
  logic        wr_err_en = 0, rd_bad_en = 0, ar_block = 0;
  logic [31:0] wr_err_addr = '0, rd_bad_addr = '0, rd_bad_data = '0;
  logic [31:0] mem [16];
  logic        got_aw, got_w, hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic [31:0] aw_l, w_l, cap_aw, cap_w, cap_ar;

  task automatic slave_clear();
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
    got_aw = 0; got_w = 0; hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0; aw_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    aw_l = '0; w_l = '0; cap_aw = '0; cap_w = '0; cap_ar = '0;
    slave_clear();
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        slave_clear();
      end else begin
        if (hs_b) M_AXI_BVALID = 0;
        if (hs_r) M_AXI_RVALID = 0;
        if (hs_aw) begin got_aw = 1; aw_l = cap_aw; aw_cnt = 0; end
        if (hs_w) begin got_w = 1; w_l = cap_w; end
        if (hs_ar) begin
          M_AXI_RVALID = 1;
          M_AXI_RRESP  = 2'b00;
          M_AXI_RDATA  = (rd_bad_en && cap_ar == rd_bad_addr) ? rd_bad_data : mem[cap_ar[5:2]];
        end
        if (got_aw && got_w) begin
          got_aw = 0; got_w = 0; M_AXI_BVALID = 1;
          if (wr_err_en && aw_l == wr_err_addr) M_AXI_BRESP = 2'b10;
          else begin
            M_AXI_BRESP = 2'b00;
            mem[aw_l[5:2]] = w_l;
          end
        end
        if (M_AXI_AWVALID && !got_aw) begin
          M_AXI_AWREADY = (aw_cnt >= aw_delay);
          aw_cnt++;
        end else M_AXI_AWREADY = 0;
        M_AXI_WREADY  = M_AXI_WVALID && !got_w;
        M_AXI_ARREADY = M_AXI_ARVALID && !ar_block;
        #1;
        hs_aw = M_AXI_AWVALID && M_AXI_AWREADY; cap_aw = M_AXI_AWADDR;
        hs_w  = M_AXI_WVALID && M_AXI_WREADY;   cap_w  = M_AXI_WDATA;
        hs_b  = M_AXI_BVALID && M_AXI_BREADY;
        hs_ar = M_AXI_ARVALID && M_AXI_ARREADY; cap_ar = M_AXI_ARADDR;
        hs_r  = M_AXI_RVALID && M_AXI_RREADY;
      end
    end
  end

  // Monitor: pops expected values whenever a transfer or completion is visible
  int         b_count = 0, ar_valid_cycles = 0, end_cyc = 0, rdreq_cyc = 0, err_cyc = 0;
  logic       done_p = 0, error_p = 0;
  logic [2:0] st_p = '0;

  initial forever begin
    @(negedge ACLK);
    #2;
    if (ARESETN) begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        if (exp_aw_q.size() == 0) unexpected("aw_addr", M_AXI_AWADDR);
        else check("aw_addr", M_AXI_AWADDR, exp_aw_q.pop_front());
        check("aw_prot", {29'd0, M_AXI_AWPROT}, 32'd0);
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        if (exp_w_q.size() == 0) unexpected("w_data", M_AXI_WDATA);
        else check("w_data", M_AXI_WDATA, exp_w_q.pop_front());
        check("w_strb", {28'd0, M_AXI_WSTRB}, 32'hF);
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        if (exp_ar_q.size() == 0) unexpected("ar_addr", M_AXI_ARADDR);
        else check("ar_addr", M_AXI_ARADDR, exp_ar_q.pop_front());
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        if (exp_r_q.size() == 0) unexpected("r_data", M_AXI_RDATA);
        else check("r_data", M_AXI_RDATA, exp_r_q.pop_front());
      end
      if (M_AXI_BVALID && M_AXI_BREADY) b_count++;
      if (M_AXI_ARVALID) ar_valid_cycles++;
      if ((done && !done_p) || (error && !error_p)) begin
        end_cyc = cyc;
        if (exp_end_q.size() == 0) unexpected("end_status", {24'd0, done, error, err_code, err_index});
        else check("end_status", {24'd0, done, error, err_code, err_index}, {24'd0, exp_end_q.pop_front()});
      end
      if (dbg_state == ST_RD_REQ && st_p != ST_RD_REQ) rdreq_cyc = cyc;
      if (dbg_state == ST_ERR && st_p != ST_ERR) err_cyc = cyc;
    end
    done_p = done; error_p = error; st_p = dbg_state;
  end

  // Driver tasks
  int start_cyc = 0;

  task automatic push_writes(input logic [127:0] cfg, input int n);
    for (int i = 0; i < n; i++) begin
      exp_aw_q.push_back(32'(4 * i));
      exp_w_q.push_back(cfg[32*i +: 32]);
    end
  endtask

  task automatic push_reads(input logic [127:0] cfg, input int n);
    for (int i = 0; i < n; i++) begin
      exp_ar_q.push_back(32'(4 * i));
      exp_r_q.push_back(cfg[32*i +: 32]);
    end
  endtask

  task automatic pulse_start(input logic [127:0] cfg);
    @(negedge ACLK);
    cfg_data = cfg;
    start    = 1'b1;
    @(negedge ACLK);
    start           = 1'b0;
    start_cyc       = cyc;
    b_count         = 0;
    ar_valid_cycles = 0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 400) begin
      @(negedge ACLK);
      #3;
      n++;
    end
    if (!(done || error)) begin
      checks++;
      fails++;
      $display("FAIL end_wait: got no done/error expected completion within 400 cycles");
    end
  endtask

  task automatic queues_empty(input string name);
    check({name, "_aw_left"}, exp_aw_q.size(), 0);
    check({name, "_w_left"}, exp_w_q.size(), 0);
    check({name, "_ar_left"}, exp_ar_q.size(), 0);
    check({name, "_r_left"}, exp_r_q.size(), 0);
    check({name, "_end_left"}, exp_end_q.size(), 0);
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_r_q.delete(); exp_end_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_awvalid"}, M_AXI_AWVALID, 0);
    check({name, "_wvalid"}, M_AXI_WVALID, 0);
    check({name, "_arvalid"}, M_AXI_ARVALID, 0);
    check({name, "_bready"}, M_AXI_BREADY, 0);
    check({name, "_rready"}, M_AXI_RREADY, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [127:0] cfg;
    int aw_hi, w_hi, n;
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100us");
    $fatal(1, "watchdog");
  end

  // Directed scenarios
  initial begin
    logic [127:0] cfg;
    int aw_hi, w_hi, n;
    ARESETN = 1'b0; start = 1'b0; cfg_data = '0;
    #100;
    check_idle_outputs("rst");
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_code", err_code, 0);
    check("rst_index", err_index, 0);
    check("rst_state", dbg_state, ST_IDLE);
    #103;
    ARESETN = 1'b1;

    // Normal sequence
    cfg = {32'd4, 32'd3, 32'd2, 32'd1};
    push_writes(cfg, 4); push_reads(cfg, 4);
    exp_end_q.push_back({1'b1, 1'b0, 2'b00, 4'd0});
    pulse_start(cfg);
    #1;
    check("norm_busy_rise", busy, 1);
    check("norm_awvalid_rise", M_AXI_AWVALID, 1);
    check("norm_wvalid_rise", M_AXI_WVALID, 1);
    wait_end();
    check("norm_latency", end_cyc - start_cyc, 16);
    check("norm_done", done, 1);
    check("norm_error", error, 0);
    check("norm_busy_fall", busy, 0);
    check("norm_b_count", b_count, 4);
    queues_empty("norm");

    // AWREADY delayed 3 cycles, WREADY immediate
    aw_delay = 3;
    cfg = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    push_writes(cfg, 4); push_reads(cfg, 4);
    exp_end_q.push_back({1'b1, 1'b0, 2'b00, 4'd0});
    pulse_start(cfg);
    aw_hi = 0; w_hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge ACLK);
      #2;
      if (i == 0) check("skew_done_cleared", done, 0);
      aw_hi += int'(M_AXI_AWVALID);
      w_hi  += int'(M_AXI_WVALID);
    end
    check("skew_awvalid_cycles", aw_hi, 4);
    check("skew_wvalid_cycles", w_hi, 1);
    wait_end();
    check("skew_b_count", b_count, 4);
    check("skew_done", done, 1);
    queues_empty("skew");
    aw_delay = 0;

    // SLVERR on the write to 0x8
    wr_err_en = 1; wr_err_addr = 32'h8;
    cfg = {32'h0000_0D0D, 32'h0000_0C0C, 32'h0000_0B0B, 32'h0000_0A0A};
    push_writes(cfg, 3);
    exp_end_q.push_back({1'b0, 1'b1, 2'b01, 4'd2});
    pulse_start(cfg);
    wait_end();
    repeat (3) @(negedge ACLK);
    #3;
    check("werr_error", error, 1);
    check("werr_code", err_code, 2'b01);
    check("werr_index", err_index, 4'd2);
    check("werr_no_ar", ar_valid_cycles, 0);
    queues_empty("werr");
    wr_err_en = 0;

    // Readback of 0x4 corrupted
    rd_bad_en = 1; rd_bad_addr = 32'h4; rd_bad_data = 32'h0000_DEAD;
    cfg = {32'h1234_0003, 32'h1234_0002, 32'h1234_0001, 32'h1234_0000};
    push_writes(cfg, 4);
    exp_ar_q.push_back(32'h0); exp_r_q.push_back(32'h1234_0000);
    exp_ar_q.push_back(32'h4); exp_r_q.push_back(32'h0000_DEAD);
    exp_end_q.push_back({1'b0, 1'b1, 2'b10, 4'd1});
    pulse_start(cfg);
    wait_end();
    repeat (3) @(negedge ACLK);
    #3;
    check("mism_code", err_code, 2'b10);
    check("mism_index", err_index, 4'd1);
    check("mism_ar_cycles", ar_valid_cycles, 2);
    queues_empty("mism");
    rd_bad_en = 0;

    // ARREADY stuck low
    ar_block = 1;
    cfg = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
    push_writes(cfg, 4);
    exp_end_q.push_back({1'b0, 1'b1, 2'b11, 4'd0});
    pulse_start(cfg);
    wait_end();
    check("tmo_cycles", err_cyc - rdreq_cyc, 16);
    check("tmo_code", err_code, 2'b11);
    check("tmo_ar_cycles", ar_valid_cycles, 16);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      #3;
      check("tmo_arvalid_low", M_AXI_ARVALID, 0);
    end
    queues_empty("tmo");
    ar_block = 0;

    // Asynchronous reset during the second write, then restart
    cfg = {32'h44, 32'h33, 32'h22, 32'h11};
    exp_aw_q.push_back(32'h0); exp_w_q.push_back(32'h11);
    pulse_start(cfg);
    n = 0;
    while (!(M_AXI_AWVALID && M_AXI_AWADDR == 32'h4) && n < 20) begin
      @(posedge ACLK);
      #1;
      n++;
    end
    check("rst2_second_write_seen", M_AXI_AWADDR, 32'h4);
    #2;
    ARESETN = 1'b0;
    #1;
    check_idle_outputs("rst2");
    check("rst2_state", dbg_state, ST_IDLE);
    queues_empty("rst2");
    @(negedge ACLK);
    @(negedge ACLK);
    #3;
    ARESETN = 1'b1;

    push_writes(cfg, 4); push_reads(cfg, 4);
    exp_end_q.push_back({1'b1, 1'b0, 2'b00, 4'd0});
    pulse_start(cfg);
    repeat (3) @(negedge ACLK);
    cfg_data = {4{32'hFFFF_FFFF}};
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    wait_end();
    check("restart_latency", end_cyc - start_cyc, 16);
    check("restart_done", done, 1);
    check("restart_b_count", b_count, 4);
    queues_empty("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
